instr_fetch: RTL and testbench

Instruction fetch stage of the RISwitch core. Owns the program counter, drives the instruction-memory address port, pairs each returning instruction word (valid one cycle after the address is presented) with its PC, and presents it to decode through a valid/ready handshake. A one-entry hold register absorbs decode back-pressure. A redirect port from execute squashes in-flight work for branches, jumps and traps.

---
 rtl/instr_fetch.sv | 122 ++++++++++++
 tb/tb_instr_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage of the RISwitch core. Owns the program counter,
// drives the instruction-memory address, pairs each returning word (valid one
// cycle after its address) with its PC and hands it to decode. A one-entry
// hold register absorbs decode back-pressure. A redirect from execute squashes
// all in-flight work and restarts fetch at a new target.
//
// Ports
//   clock           in   single clock, all state updates on posedge
//   reset           in   synchronous, active-high
//   imem_addr       out  address presented to instruction memory
//   imem_instr      in   word for the address sampled at the previous posedge
//   redirect_valid  in   squash and restart fetch at redirect_target
//   redirect_target in   new PC, bits [1:0] are ignored (forced to 0)
//   out_valid       out  out_pc/out_instr carry a fetched instruction
//   out_ready       in   decode accepts this cycle
//   out_pc          out  PC of the presented instruction
//   out_instr       out  presented instruction word
//
// Handshake: an instruction moves to decode in any cycle where
// out_valid & out_ready are both high. Once out_valid is raised, out_pc and
// out_instr stay unchanged until that transfer happens, unless a redirect or
// reset squashes the instruction. out_valid never depends on out_ready.
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter int                   addrWidth   = 32,
   parameter int                   instrWidth  = 32,
   parameter logic [addrWidth-1:0] resetVector = 32'h8000_0000
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic [addrWidth-1:0]  imem_addr,
   input  logic [instrWidth-1:0] imem_instr,
   input  logic                  redirect_valid,
   input  logic [addrWidth-1:0]  redirect_target,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [addrWidth-1:0]  out_pc,
   output logic [instrWidth-1:0] out_instr
);

   // Program counter: next address to request.
   logic [addrWidth-1:0]  pc;

   // Request issued last cycle; its data is on imem_instr now.
   logic                  req_valid;
   logic [addrWidth-1:0]  req_pc;

   // Hold entry for a word decode refused.
   logic                  hold_valid;
   logic [addrWidth-1:0]  hold_pc;
   logic [instrWidth-1:0] hold_instr;

   logic                  redirect;
   logic [addrWidth-1:0]  redirect_addr;
   logic                  stall;
   logic                  issue;
   logic                  capture;
   logic [1:0]            unused_target_bits;

   assign unused_target_bits = redirect_target[1:0];

   // Reset outranks redirect, so a redirect is only honoured out of reset.
   assign redirect      = redirect_valid & ~reset;
   assign redirect_addr = {redirect_target[addrWidth-1:2], 2'b00};

   // Presented entry: the hold register always wins because it is older than
   // anything in the request slot.
   always_comb begin
      out_valid = (hold_valid | req_valid) & ~redirect_valid & ~reset;
      out_pc    = req_pc;
      out_instr = imem_instr;
      if (hold_valid) begin
         out_pc    = hold_pc;
         out_instr = hold_instr;
      end
   end

   assign stall = out_valid & ~out_ready;
   assign issue = redirect | ~stall;

   // When not issuing the address still shows pc; memory reads it anyway and
   // the returned word is ignored because req_valid drops.
   assign imem_addr = redirect ? redirect_addr : pc;

   // A refused word coming straight from memory must be parked, since the
   // memory port will not repeat it. The capture cycle is a stall cycle, so
   // no new request is issued and hold/req never fill together.
   assign capture = req_valid & ~hold_valid & ~out_ready & ~redirect_valid;

   always_ff @(posedge clock) begin
      if (reset) begin
         pc         <= resetVector;
         req_valid  <= 1'b0;
         hold_valid <= 1'b0;
      end else if (redirect) begin
         pc         <= redirect_addr + addrWidth'(4);
         req_pc     <= redirect_addr;
         req_valid  <= 1'b1;
         hold_valid <= 1'b0;
      end else begin
         if (issue) begin
            pc        <= pc + addrWidth'(4);
            req_pc    <= pc;
            req_valid <= 1'b1;
         end else begin
            req_valid <= 1'b0;
         end

         if (capture) begin
            hold_valid <= 1'b1;
            hold_pc    <= req_pc;
            hold_instr <= imem_instr;
         end else if (hold_valid && out_ready) begin
            hold_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch. Memory returns addr ^ 32'hA5A5_A5A5
// one cycle after the address. A second instance with resetVector at the top
// of the address space covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   localparam logic [31:0] PAT = 32'hA5A5_A5A5;

   logic        clock;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;

   logic [31:0] imem_addr_w;
   logic [31:0] imem_instr_w;
   logic        out_valid_w;
   logic [31:0] out_pc_w;
   logic [31:0] out_instr_w;

   int n_checks = 0;
   int n_pass   = 0;
   int n_xfer   = 0;
   logic [31:0] exp_pc;
   logic [31:0] exp_q[$];

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- DUTs and memory models ----------------
   instr_fetch dut (
      .clock           (clock),
      .reset           (reset),
      .imem_addr       (imem_addr),
      .imem_instr      (imem_instr),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_instr       (out_instr)
   );

   instr_fetch #(.resetVector(32'hFFFF_FFFC)) dut_w (
      .clock           (clock),
      .reset           (reset),
      .imem_addr       (imem_addr_w),
      .imem_instr      (imem_instr_w),
      .redirect_valid  (1'b0),
      .redirect_target (32'h0),
      .out_valid       (out_valid_w),
      .out_ready       (1'b1),
      .out_pc          (out_pc_w),
      .out_instr       (out_instr_w)
   );

   always @(posedge clock) begin
      imem_instr   <= imem_addr ^ PAT;
      imem_instr_w <= imem_addr_w ^ PAT;
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // ---------------- driver ----------------
   // Advance one cycle, then drive inputs; outputs are sampled by the caller
   // 2 time units after the edge, well before the next one.
   task automatic step(input logic rst, input logic rdy, input logic rv, input logic [31:0] tgt);
      @(posedge clock);
      #1;
      reset           = rst;
      out_ready       = rdy;
      redirect_valid  = rv;
      redirect_target = tgt;
      #1;
   endtask

   task automatic check_out(input string tag, input logic [31:0] pc);
      check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, "_pc"}, out_pc, pc);
      check({tag, "_instr"}, out_instr, pc ^ PAT);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset           = 1'b1;
      out_ready       = 1'b1;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;

      // Reset held: nothing valid, address shows the reset PC.
      step(1, 1, 0, 0);
      check("rst_valid", {31'b0, out_valid}, 32'd0);
      check("rst_addr", imem_addr, 32'h8000_0000);

      // Release: first cycle issues resetVector, nothing presented yet.
      step(0, 1, 0, 0);
      check("first_valid", {31'b0, out_valid}, 32'd0);
      check("first_addr", imem_addr, 32'h8000_0000);
      check("w_first_valid", {31'b0, out_valid_w}, 32'd0);

      step(0, 1, 0, 0);
      check_out("seq0", 32'h8000_0000);
      check("seq0_addr", imem_addr, 32'h8000_0004);
      check("w_pc0", out_pc_w, 32'hFFFF_FFFC);
      check("w_instr0", out_instr_w, 32'h5A5A_5A59);

      step(0, 1, 0, 0);
      check_out("seq1", 32'h8000_0004);
      check("w_valid1", {31'b0, out_valid_w}, 32'd1);
      check("w_pc1", out_pc_w, 32'h0000_0000);
      check("w_instr1", out_instr_w, 32'hA5A5_A5A5);

      // Stall three cycles on 0x8000_0008, accept it, then 0x8000_000C.
      step(0, 0, 0, 0);
      check_out("stall0", 32'h8000_0008);
      check("stall0_instr_lit", out_instr, 32'h25A5_A5AD);
      step(0, 0, 0, 0);
      check_out("stall1", 32'h8000_0008);
      step(0, 0, 0, 0);
      check_out("stall2", 32'h8000_0008);
      step(0, 1, 0, 0);
      check_out("stall_accept", 32'h8000_0008);
      check("stall_accept_addr", imem_addr, 32'h8000_000C);
      step(0, 1, 0, 0);
      check_out("after_stall", 32'h8000_000C);

      // Redirect while streaming: 0x8000_0010 is in flight and must vanish.
      step(0, 1, 1, 32'h8000_0102);
      check("rdr_valid", {31'b0, out_valid}, 32'd0);
      check("rdr_addr", imem_addr, 32'h8000_0100);
      step(0, 1, 0, 0);
      check_out("rdr_tgt", 32'h8000_0100);
      check("rdr_tgt_instr_lit", out_instr, 32'h25A5_A4A5);
      step(0, 1, 0, 0);
      check_out("rdr_next", 32'h8000_0104);

      // Fill the hold entry, then redirect with it full.
      step(0, 0, 0, 0);
      check_out("hold_fill", 32'h8000_0108);
      step(0, 0, 0, 0);
      check_out("hold_full", 32'h8000_0108);
      check("hold_full_flag", {31'b0, dut.hold_valid}, 32'd1);
      step(0, 0, 1, 32'h8000_0200);
      check("hold_rdr_valid", {31'b0, out_valid}, 32'd0);
      check("hold_rdr_addr", imem_addr, 32'h8000_0200);
      step(0, 1, 0, 0);
      check_out("hold_rdr_tgt", 32'h8000_0200);

      // Reset mid-stall with the hold entry full.
      step(0, 0, 0, 0);
      check_out("rst_stall_fill", 32'h8000_0204);
      step(1, 0, 0, 0);
      check("rst_stall_valid", {31'b0, out_valid}, 32'd0);
      step(0, 1, 0, 0);
      check("rst_after_valid", {31'b0, out_valid}, 32'd0);
      check("rst_after_addr", imem_addr, 32'h8000_0000);
      step(0, 1, 0, 0);
      check_out("rst_restart", 32'h8000_0000);

      // Random back-pressure and redirects against an in-order stream model.
      exp_q.delete();
      exp_q.push_back(32'h8000_0004);
      for (int i = 0; i < 400; i++) begin
         logic        rdy;
         logic        rv;
         logic [31:0] tgt;
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 15) == 0);
         tgt = $urandom;
         step(0, rdy, rv, tgt);
         check("hold_req_excl", {31'b0, dut.hold_valid & dut.req_valid}, 32'd0);
         if (rv) begin
            check("rnd_rdr_valid", {31'b0, out_valid}, 32'd0);
            exp_q.delete();
            exp_q.push_back({tgt[31:2], 2'b00});
         end else if (out_valid && out_ready) begin
            exp_pc = exp_q.pop_front();
            check("rnd_pc", out_pc, exp_pc);
            check("rnd_instr", out_instr, exp_pc ^ PAT);
            exp_q.push_back(exp_pc + 32'd4);
            n_xfer++;
         end
      end
      check("rnd_progress", {31'b0, n_xfer >= 100}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
